// File: rtl/lfsr_random_source.sv
// Fibonacci LFSR pseudo-random word source.
// The state shifts right by one on each requested advance, and the XOR of the
// tapped bits enters at the MSB. o_rand is driven straight from the state
// register, so i_next has no combinational path to the output.
// The all-zero lock-up state is never reached from a legal seed. If a glitch
// produces it anyway, the block reloads the seed on the next edge.
module lfsr_random_source #(
    parameter int unsigned          WIDTH = 16,
    parameter logic [WIDTH-1:0]     TAPS  = 16'h002D,
    parameter logic [WIDTH-1:0]     SEED  = 16'hACE1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_next,
    output logic [WIDTH-1:0] o_rand
);

    // A zero seed would lock the register, so substitute 1 in that case.
    localparam logic [WIDTH-1:0] SEED_EFF =
        (SEED == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic             state_zero_s;

    // Parity of the tapped state bits, which is the new MSB on each advance.
    function automatic logic lfsr_feedback(input logic [WIDTH-1:0] st);
        return ^(st & TAPS);
    endfunction

    assign state_zero_s = (state_q == {WIDTH{1'b0}});

    // Next-state selection: the lock-up guard first, then advance, otherwise hold.
    always_comb begin
        state_d = state_q;
        if (state_zero_s) begin
            state_d = SEED_EFF;
        end else if (i_next) begin
            state_d = {lfsr_feedback(state_q), state_q[WIDTH-1:1]};
        end else begin
            state_d = state_q;
        end
    end

    // State register: reset loads the seed asynchronously and dominates i_next.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= SEED_EFF;
        end else begin
            state_q <= state_d;
        end
    end

    assign o_rand = state_q;

endmodule

// File: tb/tb_lfsr_random_source.sv
// Directed testbench for lfsr_random_source. Expected values are computed by hand.
module tb_lfsr_random_source;

    logic        clk;
    logic        rst_n;
    logic        next;
    logic        next0;
    logic [15:0] rand_w;
    logic [15:0] rand0_w;

    int errors;
    int checks;

    lfsr_random_source #(
        .WIDTH (16),
        .TAPS  (16'h002D),
        .SEED  (16'hACE1)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_next  (next),
        .o_rand  (rand_w)
    );

    lfsr_random_source #(
        .WIDTH (16),
        .TAPS  (16'h002D),
        .SEED  (16'h0000)
    ) dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_next  (next0),
        .o_rand  (rand0_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold reset low across two rising edges, then release it at a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        next  = 1'b0;
        next0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rand_w !== 16'hACE1) begin
            errors++;
            $display("FAIL reset_async: got %h expected %h", rand_w, 16'hACE1);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (rand_w !== 16'hACE1) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, rand_w, 16'hACE1);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_sequence();
        logic [15:0] exp_seq [4];
        exp_seq[0] = 16'hACE1;
        exp_seq[1] = 16'h5670;
        exp_seq[2] = 16'hAB38;
        exp_seq[3] = 16'h559C;
        do_reset();
        next = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (rand_w !== exp_seq[i]) begin
                errors++;
                $display("FAIL first_seq[%0d]: got %h expected %h", i, rand_w, exp_seq[i]);
            end
        end
        next = 1'b0;
    endtask

    task automatic test_hold();
        do_reset();
        next = 1'b1;
        @(negedge clk);
        @(negedge clk);
        next = 1'b0;
        checks++;
        if (rand_w !== 16'hAB38) begin
            errors++;
            $display("FAIL hold_start: got %h expected %h", rand_w, 16'hAB38);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rand_w !== 16'hAB38) begin
                errors++;
                $display("FAIL hold[%0d]: got %h expected %h", i, rand_w, 16'hAB38);
            end
        end
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        checks++;
        if (rand_w !== 16'h559C) begin
            errors++;
            $display("FAIL hold_resume: got %h expected %h", rand_w, 16'h559C);
        end
    endtask

    task automatic test_period();
        int zero_seen;
        int early_cnt;
        zero_seen = 0;
        early_cnt = 0;
        do_reset();
        next = 1'b1;
        for (int cnt = 1; cnt <= 65535; cnt++) begin
            @(negedge clk);
            if (rand_w === 16'h0000) zero_seen++;
            if (cnt < 65535 && rand_w === 16'hACE1) early_cnt++;
        end
        next = 1'b0;
        checks++;
        if (rand_w !== 16'hACE1) begin
            errors++;
            $display("FAIL period_end: got %h expected %h", rand_w, 16'hACE1);
        end
        checks++;
        if (early_cnt !== 0) begin
            errors++;
            $display("FAIL period_early: got %0d early repeats expected 0", early_cnt);
        end
        checks++;
        if (zero_seen !== 0) begin
            errors++;
            $display("FAIL period_zero: got %0d zero words expected 0", zero_seen);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        next = 1'b1;
        repeat (100) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rand_w !== 16'hACE1) begin
            errors++;
            $display("FAIL reset_mid_async: got %h expected %h", rand_w, 16'hACE1);
        end
        // i_next stays high across an edge while reset is held low.
        @(negedge clk);
        checks++;
        if (rand_w !== 16'hACE1) begin
            errors++;
            $display("FAIL reset_dominates: got %h expected %h", rand_w, 16'hACE1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rand_w !== 16'h5670) begin
            errors++;
            $display("FAIL reset_mid_seq1: got %h expected %h", rand_w, 16'h5670);
        end
        @(negedge clk);
        checks++;
        if (rand_w !== 16'hAB38) begin
            errors++;
            $display("FAIL reset_mid_seq2: got %h expected %h", rand_w, 16'hAB38);
        end
        next = 1'b0;
    endtask

    task automatic test_zero_guard();
        do_reset();
        next = 1'b1;
        @(negedge clk);
        @(negedge clk);
        next = 1'b0;
        dut.state_q = 16'h0000;
        #1;
        checks++;
        if (rand_w !== 16'h0000) begin
            errors++;
            $display("FAIL zero_forced: got %h expected %h", rand_w, 16'h0000);
        end
        @(negedge clk);
        checks++;
        if (rand_w !== 16'hACE1) begin
            errors++;
            $display("FAIL zero_guard: got %h expected %h", rand_w, 16'hACE1);
        end
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        checks++;
        if (rand_w !== 16'h5670) begin
            errors++;
            $display("FAIL zero_guard_next: got %h expected %h", rand_w, 16'h5670);
        end
    endtask

    task automatic test_seed_zero();
        @(negedge clk);
        rst_n = 1'b0;
        next0 = 1'b0;
        @(negedge clk);
        checks++;
        if (rand0_w !== 16'h0001) begin
            errors++;
            $display("FAIL seed_zero_reset: got %h expected %h", rand0_w, 16'h0001);
        end
        rst_n = 1'b1;
        next0 = 1'b1;
        @(negedge clk);
        checks++;
        if (rand0_w !== 16'h8000) begin
            errors++;
            $display("FAIL seed_zero_adv1: got %h expected %h", rand0_w, 16'h8000);
        end
        @(negedge clk);
        next0 = 1'b0;
        checks++;
        if (rand0_w !== 16'h4000) begin
            errors++;
            $display("FAIL seed_zero_adv2: got %h expected %h", rand0_w, 16'h4000);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b1;
        next   = 1'b0;
        next0  = 1'b0;
        test_reset();
        test_first_sequence();
        test_hold();
        test_reset_mid();
        test_zero_guard();
        test_seed_zero();
        test_period();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
